// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter with an 8-entry byte FIFO.
//               Define MMIO_UART_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned c_div_raw = CLK_HZ / BAUD;
    localparam int unsigned c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int unsigned c_cnt_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(c_div - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [7:0]         r_mem [8];
    logic [2:0]         r_wr_ptr;
    logic [2:0]         r_rd_ptr;
    logic [3:0]         r_count;
    logic               r_overflow;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic w_sel_data;
    logic w_sel_status;
    logic w_full;
    logic w_empty;
    logic w_baud_done;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_unused_bits;

    assign w_sel_data   = (addr == BASE_ADDR);
    assign w_sel_status = (addr == (BASE_ADDR + 32'd4));
    assign w_full       = (r_count == 4'd8);
    assign w_empty      = (r_count == 4'd0);
    assign w_baud_done  = (r_baud_cnt == c_div_last);

    // A pop happens when idle, or on the last stop-bit cycle so frames chain without a gap.
    assign w_pop  = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));
    assign w_push = mem_write && w_sel_data && (!w_full || w_pop);
    assign w_drop = mem_write && w_sel_data && w_full && !w_pop;

    assign w_unused_bits = ^wdata[31:8];

    assign uart_tx = r_tx;
    assign tx_busy = !w_empty || (r_state != ST_IDLE);

    always_comb begin
        rdata = 32'b0;
        if (mem_read && w_sel_status) begin
            rdata = {24'b0, r_count, r_overflow, tx_busy, w_empty, w_full};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= 3'd0;
            r_rd_ptr   <= 3'd0;
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (mem_write && w_sel_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= ST_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= ^r_shift;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= ST_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
